ifft_output_collect: RTL and testbench



---
 rtl/ifft_output_collect_pkg.sv | 39 +++
 rtl/ifft_output_collect_if.sv | 26 ++
 rtl/ifft_output_collect_lane.sv | 20 ++
 rtl/ifft_output_collect.sv | 97 +++++++++
 tb/tb_ifft_output_collect.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ifft_output_collect_pkg.sv
// Shared types and constants for IFFT output collection: complex word layout, FSM states, crop geometry.
// Latency: none (package only). Backpressure: none.
package ifft_output_collect_pkg;

  localparam int DATALEN     = 16;
  localparam int PARATIL     = 9;
  localparam int FFTCHNL     = 8;
  localparam int FFTSIZE     = 8;
  localparam int KRNSIZE     = 3;
  localparam int NUMOCH      = 64;
  localparam int SCALESH_DEF = 0;
  localparam int ADDRLEN     = 12;

  localparam int VALIDW = FFTSIZE - KRNSIZE + 1;
  localparam int ROWW   = $clog2(FFTSIZE);
  localparam int CHW    = $clog2(NUMOCH);

  // real occupies the upper half of each complex word
  typedef struct packed {
    logic [DATALEN-1:0] re;
    logic [DATALEN-1:0] im;
  } cplx_t;

  typedef cplx_t [FFTCHNL-1:0]           ifft_row_t;
  typedef ifft_row_t [PARATIL-1:0]       ifft_beat_t;
  typedef logic [VALIDW-1:0][DATALEN-1:0] out_tile_t;
  typedef out_tile_t [PARATIL-1:0]       out_row_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic logic [ADDRLEN-1:0] row_addr(logic [CHW-1:0] ch, logic [ROWW-1:0] row);
    return ADDRLEN'(ch) * ADDRLEN'(VALIDW) + ADDRLEN'(row) - ADDRLEN'(KRNSIZE - 1);
  endfunction

endpackage

// File: rtl/ifft_output_collect_if.sv
// IFFT result input and output-buffer write bundle for ifft_output_collect.
// Latency: n/a. Backpressure: none; the source streams rows and the sink always accepts writes.
interface ifft_output_collect_if;
  import ifft_output_collect_pkg::*;

  logic                collectstart;
  logic                relu_en;
  logic                ifftoutvalid;
  ifft_beat_t          ifftout;
  logic                wrout;
  logic [ADDRLEN-1:0]  wraddr;
  out_row_t            wrdata;
  logic                collectbusy;
  logic                collectdone;

  modport master (
    output collectstart, relu_en, ifftoutvalid, ifftout,
    input  wrout, wraddr, wrdata, collectbusy, collectdone
  );

  modport slave (
    input  collectstart, relu_en, ifftoutvalid, ifftout,
    output wrout, wraddr, wrdata, collectbusy, collectdone
  );

endinterface

// File: rtl/ifft_output_collect_lane.sv
// Per-value real extract, arithmetic scale-down and optional ReLU; purely combinational.
// Latency: 0 cycles. Backpressure: none.
module collect_lane_proc
  import ifft_output_collect_pkg::*;
#(
  parameter int SCALESH = SCALESH_DEF
) (
  input  cplx_t              word,
  input  logic               relu,
  output logic [DATALEN-1:0] res
);

  logic signed [DATALEN-1:0] shifted;
  logic [DATALEN-1:0]        unused_im;

  assign unused_im = word.im;
  assign shifted   = $signed(word.re) >>> SCALESH;
  assign res       = (relu && shifted[DATALEN-1]) ? '0 : shifted;

endmodule

// File: rtl/ifft_output_collect.sv
// Crops each 8x8 IFFT block to its valid region and writes kept rows to the output buffer; 1-cycle beat-to-write latency.
// Backpressure: none; every valid beat in COLLECT is consumed, gaps between beats are allowed.
module ifft_output_collect
  import ifft_output_collect_pkg::*;
#(
  parameter int SCALESH = SCALESH_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  ifft_output_collect_if.slave bus
);

  state_t             state, state_nxt;
  logic [ROWW-1:0]    row_cnt;
  logic [CHW-1:0]     ch_cnt;
  logic               relu_q;
  logic               wrout_q;
  logic               done_q;
  logic [ADDRLEN-1:0] wraddr_q;
  out_row_t           wrdata_q;
  out_row_t           proc;
  logic               beat;
  logic               kept;
  logic               last_beat;
  logic [PARATIL-1:0] unused_cols;

  assign beat      = (state == COLLECT) && bus.ifftoutvalid;
  assign kept      = row_cnt >= ROWW'(KRNSIZE - 1);
  assign last_beat = beat && (ch_cnt == CHW'(NUMOCH - 1)) && (row_cnt == ROWW'(FFTSIZE - 1));

  // only the columns surviving the overlap-save crop are processed
  for (genvar t = 0; t < PARATIL; t++) begin : g_tile
    for (genvar k = 0; k < VALIDW; k++) begin : g_col
      collect_lane_proc #(.SCALESH(SCALESH)) u_lane (
        .word (bus.ifftout[t][k+KRNSIZE-1]),
        .relu (relu_q),
        .res  (proc[t][k])
      );
    end
    if (KRNSIZE > 1) begin : g_drop
      assign unused_cols[t] = ^bus.ifftout[t][KRNSIZE-2:0];
    end else begin : g_nodrop
      assign unused_cols[t] = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.collectstart) state_nxt = COLLECT;
      COLLECT: if (last_beat)        state_nxt = DONE;
      DONE:                          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      row_cnt  <= '0;
      ch_cnt   <= '0;
      relu_q   <= 1'b0;
      wrout_q  <= 1'b0;
      done_q   <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
    end else begin
      state   <= state_nxt;
      done_q  <= (state == DONE);
      wrout_q <= beat && kept;
      if ((state == IDLE) && bus.collectstart) begin
        row_cnt <= '0;
        ch_cnt  <= '0;
        relu_q  <= bus.relu_en;
      end
      if (beat) begin
        if (row_cnt == ROWW'(FFTSIZE - 1)) begin
          row_cnt <= '0;
          ch_cnt  <= ch_cnt + 1'b1;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
        if (kept) begin
          wraddr_q <= row_addr(ch_cnt, row_cnt);
          wrdata_q <= proc;
        end
      end
    end
  end

  assign bus.wrout       = wrout_q;
  assign bus.wraddr      = wraddr_q;
  assign bus.wrdata      = wrdata_q;
  assign bus.collectbusy = (state == COLLECT);
  assign bus.collectdone = done_q;

endmodule

// File: tb/tb_ifft_output_collect.sv
// Randomized bench for ifft_output_collect against a beat-count reference model; two instances cover SCALESH 0 and 2.
// Latency/backpressure: checks the 1-cycle write latency; the source never stalls on the DUT.
module tb_ifft_output_collect;
  import ifft_output_collect_pkg::*;

  localparam int WDW = PARATIL * VALIDW * DATALEN;

  logic clk;
  logic rstn;

  ifft_output_collect_if bif0 ();
  ifft_output_collect_if bif2 ();

  ifft_output_collect #(.SCALESH(0)) dut0 (.clk(clk), .rstn(rstn), .bus(bif0));
  ifft_output_collect #(.SCALESH(2)) dut2 (.clk(clk), .rstn(rstn), .bus(bif2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: phase 0 idle, 1 collecting, 2 last write out
  int m_phase = 0;
  int m_n     = 0;
  bit m_relu  = 0;

  int   wr_cnt     = 0;
  int   done_cnt   = 0;
  int   first_addr = -1;
  int   last_addr  = -1;
  logic prev_wr    = 1'b0;

  ifft_beat_t din;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [WDW-1:0] obs, input logic [WDW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATALEN-1:0] lane_ref(logic [DATALEN-1:0] re, int sh, bit relu);
    int v;
    v = int'($signed(re));
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    return DATALEN'(v);
  endfunction

  function automatic out_row_t expect_row(ifft_beat_t b, int sh, bit relu);
    out_row_t r;
    for (int t = 0; t < PARATIL; t++)
      for (int k = 0; k < VALIDW; k++)
        r[t][k] = lane_ref(b[t][k+KRNSIZE-1].re, sh, relu);
    return r;
  endfunction

  task automatic apply(input bit start, input bit relu, input bit valid);
    bif0.collectstart = start;  bif2.collectstart = start;
    bif0.relu_en      = relu;   bif2.relu_en      = relu;
    bif0.ifftoutvalid = valid;  bif2.ifftoutvalid = valid;
    bif0.ifftout      = din;    bif2.ifftout      = din;
  endtask

  task automatic tick();
    bit         s_rstn, s_start, s_relu, s_valid;
    ifft_beat_t s_din;
    bit         e_wr, e_done;
    logic [ADDRLEN-1:0] e_addr;
    out_row_t   e0, e2;
    int         row, ch;
    s_rstn = rstn; s_start = bif0.collectstart; s_relu = bif0.relu_en;
    s_valid = bif0.ifftoutvalid; s_din = bif0.ifftout;
    e_wr = 0; e_done = 0; e_addr = '0; e0 = '0; e2 = '0;
    @(posedge clk);
    #1;
    if (!s_rstn) begin
      m_phase = 0; m_n = 0; m_relu = 0;
    end else begin
      case (m_phase)
        0: if (s_start) begin m_phase = 1; m_n = 0; m_relu = s_relu; end
        1: if (s_valid) begin
          row = m_n % FFTSIZE;
          ch  = m_n / FFTSIZE;
          if (row >= KRNSIZE - 1) begin
            e_wr   = 1;
            e_addr = ADDRLEN'((ch * VALIDW + row - (KRNSIZE - 1)) % (1 << ADDRLEN));
            e0     = expect_row(s_din, 0, m_relu);
            e2     = expect_row(s_din, 2, m_relu);
          end
          m_n++;
          if (m_n == NUMOCH * FFTSIZE) m_phase = 2;
        end
        default: begin m_phase = 0; e_done = 1; end
      endcase
    end
    chk_b("wrout0", bif0.wrout, e_wr);
    chk_b("wrout2", bif2.wrout, e_wr);
    chk_b("busy0", bif0.collectbusy, m_phase == 1);
    chk_b("busy2", bif2.collectbusy, m_phase == 1);
    chk_b("done0", bif0.collectdone, e_done);
    chk_b("done2", bif2.collectdone, e_done);
    if (e_wr || !s_rstn) begin
      chk_v("wraddr0", WDW'(bif0.wraddr), WDW'(e_addr));
      chk_v("wraddr2", WDW'(bif2.wraddr), WDW'(e_addr));
      chk_v("wrdata0", bif0.wrdata, e0);
      chk_v("wrdata2", bif2.wrdata, e2);
    end
    if (bif0.wrout === 1'b1) begin
      if (wr_cnt == 0) first_addr = int'(bif0.wraddr);
      wr_cnt++;
      last_addr = int'(bif0.wraddr);
    end
    if (bif0.collectdone === 1'b1) begin
      done_cnt++;
      chk_b("done_after_write", prev_wr, 1'b1);
    end
    prev_wr = bif0.wrout;
  endtask

  task automatic set_pattern(input int i);
    for (int t = 0; t < PARATIL; t++)
      for (int c = 0; c < FFTCHNL; c++) begin
        din[t][c].re = DATALEN'(i * 10 + c);
        din[t][c].im = 16'h7FFF;
      end
  endtask

  task automatic set_random();
    for (int t = 0; t < PARATIL; t++)
      for (int c = 0; c < FFTCHNL; c++) begin
        din[t][c].re = DATALEN'($urandom);
        din[t][c].im = DATALEN'($urandom);
      end
    din[0][2].re = 16'h8001;
    din[0][3].re = 16'h0005;
    din[0][4].re = 16'hFFF0;
  endtask

  task automatic run_beats(input int count);
    for (int n = 0; n < count; n++) begin
      repeat ($urandom_range(0, 3)) begin apply(0, 0, 0); tick(); end
      set_random();
      apply(0, 0, 1);
      tick();
    end
    apply(0, 0, 0);
  endtask

  initial begin
    int snap;
    din  = '0;
    rstn = 1'b0;
    apply(0, 0, 0);
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // valid rows while idle must be ignored
    set_pattern(1);
    apply(0, 0, 1);
    repeat (3) tick();
    chk_b("idle_no_write", wr_cnt != 0, 1'b0);

    // layer 1: directed first channel, then random gaps to the end
    apply(1, 0, 0);
    tick();
    wr_cnt = 0; done_cnt = 0;
    for (int i = 0; i < FFTSIZE; i++) begin
      set_pattern(i);
      apply(0, 0, 1);
      tick();
    end
    apply(0, 0, 0);
    tick();
    chk_v("ch0_writes", WDW'(wr_cnt), WDW'(6));
    chk_v("ch0_first_addr", WDW'(first_addr), WDW'(0));
    chk_v("ch0_last_addr", WDW'(last_addr), WDW'(5));
    run_beats(NUMOCH * FFTSIZE - FFTSIZE);
    repeat (4) tick();
    chk_v("l1_writes", WDW'(wr_cnt), WDW'(NUMOCH * VALIDW));
    chk_v("l1_last_addr", WDW'(last_addr), WDW'(NUMOCH * VALIDW - 1));
    chk_v("l1_done_pulses", WDW'(done_cnt), WDW'(1));
    chk_b("l1_idle_busy", bif0.collectbusy, 1'b0);

    // layer 2: relu on, aborted by reset at channel 5 row 4
    apply(1, 1, 0);
    tick();
    wr_cnt = 0; done_cnt = 0;
    run_beats(5 * FFTSIZE + 5);
    chk_v("abort_writes", WDW'(wr_cnt), WDW'(5 * VALIDW + 3));
    snap = wr_cnt;
    rstn = 1'b0;
    set_random();
    apply(0, 0, 1);
    repeat (2) tick();
    chk_v("reset_no_write", WDW'(wr_cnt), WDW'(snap));
    rstn = 1'b1;
    apply(0, 0, 0);
    tick();
    chk_v("abort_no_done", WDW'(done_cnt), WDW'(0));

    // layer 3: full relu layer after the abort
    apply(1, 1, 0);
    tick();
    wr_cnt = 0; done_cnt = 0;
    run_beats(NUMOCH * FFTSIZE);
    repeat (4) tick();
    chk_v("l3_first_addr", WDW'(first_addr), WDW'(0));
    chk_v("l3_writes", WDW'(wr_cnt), WDW'(NUMOCH * VALIDW));
    chk_v("l3_done_pulses", WDW'(done_cnt), WDW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
